// File: rtl/wb_lsu.sv
// Wishbone classic load/store unit: one request at a time, byte/half/word/double
// accesses with lane selects, load extension, misalignment, bus-error and timeout reporting.
module wb_lsu #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_W-1:0]     wb_adr_o,
   output logic [DATA_W-1:0]     wb_dat_o,
   output logic [DATA_W/8-1:0]   wb_sel_o,
   output logic                  wb_we_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   input  logic [DATA_W-1:0]     wb_dat_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i
);

   localparam int SEL_W = DATA_W / 8;
   localparam int L     = $clog2(SEL_W);
   localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t              state_q;
   logic                ready_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic [ADDR_W-1:0]   adr_q;
   logic [DATA_W-1:0]   dat_q;
   logic [SEL_W-1:0]    sel_q;
   logic                we_out_q;
   logic                cyc_q;
   logic [15:0]         cnt_q;
   logic                we_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [L-1:0]        off_q;

   // Request decode, evaluated on the accept cycle
   logic                req_bad;
   logic [L-1:0]        req_off;
   logic [SEL_W-1:0]    sel_base;
   logic [DATA_W-1:0]   wdata_rep;

   assign req_off = req_addr[L-1:0];

   always_comb begin
      req_bad   = 1'b0;
      sel_base  = '1;
      wdata_rep = req_wdata;
      case (req_size)
         2'b00: begin
            sel_base  = SEL_W'(1);
            wdata_rep = {SEL_W{req_wdata[7:0]}};
         end
         2'b01: begin
            req_bad   = req_addr[0];
            sel_base  = SEL_W'(3);
            wdata_rep = {(DATA_W/16){req_wdata[15:0]}};
         end
         2'b10: begin
            req_bad   = |req_addr[1:0];
            sel_base  = SEL_W'(4'hF);
            wdata_rep = {(DATA_W/32){req_wdata[31:0]}};
         end
         default: begin
            req_bad   = (DATA_W == 32) || (|req_addr[2:0]);
            sel_base  = '1;
            wdata_rep = req_wdata;
         end
      endcase
   end

   // Load data: move the addressed lane down to bit 0, then extend by size
   logic [DATA_W-1:0] ld_shift;
   logic [DATA_W-1:0] ld_ext;

   assign ld_shift = wb_dat_i >> {off_q, 3'b000};

   always_comb begin
      ld_ext = ld_shift;
      case (size_q)
         2'b00:   ld_ext = uns_q ? DATA_W'(ld_shift[7:0])  : DATA_W'($signed(ld_shift[7:0]));
         2'b01:   ld_ext = uns_q ? DATA_W'(ld_shift[15:0]) : DATA_W'($signed(ld_shift[15:0]));
         2'b10:   ld_ext = uns_q ? DATA_W'(ld_shift[31:0]) : DATA_W'($signed(ld_shift[31:0]));
         default: ld_ext = ld_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         we_out_q     <= 1'b0;
         cyc_q        <= 1'b0;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         off_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
               if (req_valid) begin
                  ready_q <= 1'b0;
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  off_q   <= req_off;
                  if (req_bad) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else begin
                     state_q  <= BUS;
                     cyc_q    <= 1'b1;
                     adr_q    <= {req_addr[ADDR_W-1:L], {L{1'b0}}};
                     sel_q    <= sel_base << req_off;
                     dat_q    <= wdata_rep;
                     we_out_q <= req_we;
                     cnt_q    <= '0;
                  end
               end
            end
            BUS: begin
               // err outranks ack, and ack outranks the timeout on the same cycle
               if (wb_err_i || wb_ack_i || (TO_CNT != 16'd0 && cnt_q == TO_CNT)) begin
                  state_q      <= RESP;
                  cyc_q        <= 1'b0;
                  sel_q        <= '0;
                  we_out_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  if (!wb_err_i && wb_ack_i) begin
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= we_q ? '0 : ld_ext;
                  end else begin
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               ready_q      <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= '0;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               cyc_q   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_q;
   assign wb_sel_o   = sel_q;
   assign wb_we_o    = we_out_q;
   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = cyc_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Bench for wb_lsu: a 32-bit and a 64-bit instance driven with directed and random
// accesses; expectations come from a byte-level model of the access rules.
module tb_wb_lsu;

   localparam int TO32 = 4;
   localparam int TO64 = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        v32 = 1'b0, v64 = 1'b0;
   logic        we = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0;
   logic        ack32 = 1'b0, err32 = 1'b0, ack64 = 1'b0, err64 = 1'b0;
   logic [31:0] dati32 = '0;
   logic [63:0] dati64 = '0;

   logic        rdy32, rv32, re32, we32, cyc32, stb32;
   logic [31:0] rd32, adr32, dat32;
   logic [3:0]  sel32;
   logic        rdy64, rv64, re64, we64, cyc64, stb64;
   logic [63:0] rd64, dat64;
   logic [31:0] adr64;
   logic [7:0]  sel64;

   wb_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) dut32 (
      .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata[31:0]),
      .resp_valid(rv32), .resp_rdata(rd32), .resp_err(re32),
      .wb_adr_o(adr32), .wb_dat_o(dat32), .wb_sel_o(sel32), .wb_we_o(we32),
      .wb_cyc_o(cyc32), .wb_stb_o(stb32), .wb_dat_i(dati32), .wb_ack_i(ack32), .wb_err_i(err32));

   wb_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) dut64 (
      .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv64), .resp_rdata(rd64), .resp_err(re64),
      .wb_adr_o(adr64), .wb_dat_o(dat64), .wb_sel_o(sel64), .wb_we_o(we64),
      .wb_cyc_o(cyc64), .wb_stb_o(stb64), .wb_dat_i(dati64), .wb_ack_i(ack64), .wb_err_i(err64));

   // View of whichever instance is currently under test
   int          cur = 0;
   logic        m_rdy, m_rv, m_re, m_we, m_cyc, m_stb;
   logic [63:0] m_rd, m_dat;
   logic [31:0] m_adr;
   logic [7:0]  m_sel;

   always_comb begin
      if (cur == 1) begin
         m_rdy = rdy64; m_rv = rv64; m_re = re64; m_we = we64; m_cyc = cyc64; m_stb = stb64;
         m_rd = rd64; m_dat = dat64; m_adr = adr64; m_sel = sel64;
      end else begin
         m_rdy = rdy32; m_rv = rv32; m_re = re32; m_we = we32; m_cyc = cyc32; m_stb = stb32;
         m_rd = {32'b0, rd32}; m_dat = {32'b0, dat32}; m_adr = adr32; m_sel = {4'b0, sel32};
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (bytes and plain arithmetic) ----------------
   function automatic bit m_bad(input int nb, input int n, input logic [31:0] a);
      return (n > nb) || ((a % n) != 0);
   endfunction

   function automatic logic [63:0] m_mask(input int n);
      if (n >= 8) return '1;
      return (64'd1 << (8 * n)) - 64'd1;
   endfunction

   function automatic logic [63:0] m_lanes(input int nb, input int n, input logic [63:0] wd);
      logic [63:0] r = '0;
      for (int i = 0; i < nb; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] m_load(input int nb, input int n, input bit u,
                                          input logic [31:0] a, input logic [63:0] d);
      logic [63:0] v;
      v = (d >> (8 * (a % nb))) & m_mask(n);
      if (!u && n < 8 && v[8*n-1]) v = v | ~m_mask(n);
      if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   task automatic set_bus(input int which, input bit a, input bit e, input logic [63:0] d);
      if (which == 1) begin ack64 = a; err64 = e; dati64 = d; end
      else begin ack32 = a; err32 = e; dati32 = d[31:0]; end
   endtask

   // mode: 0 ack after waitc cycles, 1 err, 2 err+ack, 3 no reply (timeout), 4 reset mid-bus
   task automatic run(input int which, input bit w, input logic [1:0] sz, input bit u,
                      input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rdin,
                      input int mode, input int waitc);
      int nb = (which == 1) ? 8 : 4;
      int to = (which == 1) ? TO64 : TO32;
      int n  = 1 << sz;
      int r;
      logic [63:0] din = (nb == 4) ? {32'b0, rdin[31:0]} : rdin;
      bit bad = m_bad(nb, n, a);
      logic [63:0] exp_rd;
      bit exp_err;
      $display("txn dut%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h mode=%0d wait=%0d",
               nb * 8, w, sz, u, a, wd, din, mode, waitc);
      cur = which;
      #1;
      chk("req_ready", m_rdy, 1);
      we = w; size = sz; uns = u; addr = a; wdata = wd;
      if (which == 1) v64 = 1'b1; else v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0; v64 = 1'b0;
      if (bad) begin
         chk("bad_valid", m_rv, 1);
         chk("bad_err", m_re, 1);
         chk("bad_cyc", m_cyc, 0);
         chk("bad_rdata", m_rd, 0);
         @(posedge clk); #1;
         chk("bad_valid_drop", m_rv, 0);
         chk("bad_ready", m_rdy, 1);
         return;
      end
      r = (mode == 3) ? to + 2 : (mode == 4) ? 4 : waitc + 2;
      for (int c = 1; c < r; c++) begin
         chk("bus_cyc", m_cyc, 1);
         chk("bus_stb", m_stb, 1);
         chk("bus_no_resp", m_rv, 0);
         if (c == 1) begin
            chk("adr", m_adr, a - (a % nb));
            chk("sel", m_sel, 64'(((1 << n) - 1) << (a % nb)));
            chk("dat_o", m_dat, m_lanes(nb, n, wd));
            chk("we_o", m_we, w);
         end
         if (mode == 4 && c == 2) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("rst_cyc", m_cyc, 0);
            chk("rst_no_resp", m_rv, 0);
            @(posedge clk); #1;
            chk("rst_no_resp2", m_rv, 0);
            chk("rst_ready", m_rdy, 1);
            return;
         end
         if (c == r - 1 && mode < 3)
            set_bus(which, mode != 1, mode != 0, din);
         else
            set_bus(which, 1'b0, 1'b0, {$urandom, $urandom});
         @(posedge clk); #1;
         set_bus(which, 1'b0, 1'b0, {$urandom, $urandom});
      end
      exp_err = (mode != 0);
      exp_rd  = (mode == 0 && !w) ? m_load(nb, n, u, a, din) : 64'd0;
      chk("resp_valid", m_rv, 1);
      chk("resp_err", m_re, exp_err);
      chk("resp_rdata", m_rd, exp_rd);
      chk("resp_cyc", m_cyc, 0);
      @(posedge clk); #1;
      chk("resp_one_cycle", m_rv, 0);
      chk("ready_back", m_rdy, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         cur = k;
         #1;
         chk("rst_ready", m_rdy, 1);
         chk("rst_valid", m_rv, 0);
         chk("rst_err", m_re, 0);
         chk("rst_rdata", m_rd, 0);
         chk("rst_cyc", m_cyc, 0);
         chk("rst_stb", m_stb, 0);
         chk("rst_we", m_we, 0);
         chk("rst_sel", m_sel, 0);
         chk("rst_adr", m_adr, 0);
         chk("rst_dat", m_dat, 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      run(0, 0, 2'b00, 0, 32'h103, 64'h0, 64'h80AABBCC, 0, 0);
      run(0, 0, 2'b01, 1, 32'h202, 64'h0, 64'h9ABC1234, 0, 0);
      run(0, 1, 2'b01, 0, 32'h302, 64'h0000BEEF, 64'h0, 0, 1);
      run(0, 0, 2'b10, 0, 32'h401, 64'h0, 64'h0, 0, 0);
      run(0, 0, 2'b11, 0, 32'h400, 64'h0, 64'h0, 0, 0);
      run(0, 0, 2'b10, 0, 32'h500, 64'h0, 64'h11223344, 3, 0);
      run(0, 0, 2'b10, 0, 32'h504, 64'h0, 64'h55667788, 2, 1);
      run(0, 0, 2'b10, 1, 32'h508, 64'h0, 64'hCAFEF00D, 0, TO32);
      run(1, 0, 2'b11, 0, 32'h1008, 64'h0, 64'h0123456789ABCDEF, 0, 0);
      run(1, 0, 2'b10, 0, 32'h100C, 64'h0, 64'h0123456789ABCDEF, 0, 2);
      run(1, 0, 2'b11, 0, 32'h1010, 64'h0, 64'h0, 4, 0);
      run(1, 0, 2'b11, 0, 32'h1004, 64'h0, 64'h0, 0, 0);
      run(1, 1, 2'b00, 0, 32'h1015, 64'h5A, 64'h0, 3, 0);

      for (int i = 0; i < 150; i++) begin
         int which = $urandom_range(0, 1);
         int to = (which == 1) ? TO64 : TO32;
         logic [1:0] sz = 2'($urandom_range(0, 3));
         logic [31:0] a = $urandom;
         int p = $urandom_range(0, 99);
         int mode = (p < 60) ? 0 : (p < 75) ? 1 : (p < 85) ? 2 : (p < 95) ? 3 : 4;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         run(which, 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
             {$urandom, $urandom}, mode, $urandom_range(0, to));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
